// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with decoded fields.
// Optional MISALIGN_TRAP_EN: halt on misaligned redirect instead of masking.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ack,
  input  logic        pc_sel,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    VALID,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        take;
  logic        mis;
  logic [31:0] pc_nx;

  assign take = (state == VALID) && instr_ack;

`ifdef MISALIGN_TRAP_EN
  assign mis = pc_sel && (branch_target[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign pc_plus4 = pc + 32'd4;
  assign pc_nx    = pc_sel ? (branch_target & 32'hFFFF_FFFC)
                           : pc_plus4;

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // next-state: one request, wait for data, hold until retired
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: state_nx = WAIT;
      WAIT:  if (imem_rvalid) state_nx = VALID;
      VALID: if (instr_ack) state_nx = mis ? HALT : FETCH;
      HALT:  state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // pc advances only when the current instruction retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc <= RESET_PC;
    else if (take && !mis) pc <= pc_nx;
  end

  // instruction latch, only accepts data while a request is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              instr <= NOP;
    else if (state == WAIT && imem_rvalid) instr <= imem_rdata;
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  // sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err_q <= 1'b0;
    else if (take && mis) err_q <= 1'b1;
  end

  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked by a queue scoreboard
// against a PC-level reference model (MISALIGN_TRAP_EN aware).
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_ack(instr_ack), .pc_sel(pc_sel),
    .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr),
    .pc(pc), .pc_plus4(pc_plus4),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] req_q[$];
  exp_t        ins_q[$];

  logic [31:0] mpc;
  logic        mhalt;
  logic        merr;

  exp_t cur;
  logic was_valid;
  logic was_req;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name, logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // monitor: compare every request and every newly valid instruction
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      was_valid <= 1'b0;
      was_req   <= 1'b0;
    end else begin
      if (imem_req) begin
        if (was_req) fail("req_not_pulse", imem_addr);
        if (req_q.size() == 0) fail("unexpected_req", imem_addr);
        else chk("req_addr", imem_addr, req_q.pop_front());
      end
      if (instr_valid && !was_valid) begin
        if (ins_q.size() == 0) begin
          fail("unexpected_valid", instr);
        end else begin
          e = ins_q.pop_front();
          cur <= e;
          chk("instr", instr, e.word);
          chk("pc", pc, e.pc);
          chk("pc_plus4", pc_plus4, e.pc + 32'd4);
          chk("opcode", {25'd0, opcode}, {25'd0, e.word[6:0]});
          chk("funct3", {29'd0, funct3}, {29'd0, e.word[14:12]});
          chk("funct7", {25'd0, funct7}, {25'd0, e.word[31:25]});
          chk("rd", {27'd0, rd}, {27'd0, e.word[11:7]});
          chk("rs1", {27'd0, rs1}, {27'd0, e.word[19:15]});
          chk("rs2", {27'd0, rs2}, {27'd0, e.word[24:20]});
          chk("misalign_err", {31'd0, misalign_err}, {31'd0, merr});
        end
      end else if (instr_valid) begin
        chk("hold_instr", instr, cur.word);
        chk("hold_pc", pc, cur.pc);
      end
      was_valid <= instr_valid;
      was_req   <= imem_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail("req_timeout", 32'd50);
  endtask

  // memory side: answer the pending request after dly WAIT cycles
  task automatic serve(int dly, logic [31:0] word);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    tick();
    for (int i = 0; i < dly; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        instr_ack     = 1'b1;
        pc_sel        = 1'b1;
        branch_target = $urandom;
      end
      tick();
      instr_ack = 1'b0;
      pc_sel    = 1'b0;
    end
    ins_q.push_back(exp_t'({mpc, word}));
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
  endtask

  // execute side: retire after a random pause, update the model
  task automatic ack(logic sel, logic [31:0] tgt);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      imem_rvalid   = ($urandom_range(0, 1) == 1);
      imem_rdata    = $urandom;
      pc_sel        = ($urandom_range(0, 1) == 1);
      branch_target = $urandom;
      tick();
      imem_rvalid = 1'b0;
    end
    instr_ack     = 1'b1;
    pc_sel        = sel;
    branch_target = tgt;
    tick();
    instr_ack     = 1'b0;
    pc_sel        = ($urandom_range(0, 1) == 1);
    branch_target = $urandom;
    if (sel) begin
`ifdef MISALIGN_TRAP_EN
      if (tgt % 4 != 0) begin
        merr  = 1'b1;
        mhalt = 1'b1;
      end else begin
        mpc = tgt;
      end
`else
      mpc = tgt - (tgt % 4);
`endif
    end else begin
      mpc = mpc + 32'd4;
    end
    if (!mhalt) req_q.push_back(mpc);
  endtask

  initial begin : stim
    bit ok;
    logic sel;
    rst           = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    instr_ack     = 1'b0;
    pc_sel        = 1'b0;
    branch_target = '0;
    mpc           = RPC;
    mhalt         = 1'b0;
    merr          = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, RPC);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);

    tick();
    req_q.push_back(mpc);
    rst = 1'b0;

    serve(0, 32'h0050_0093);
    ack(1'b0, 32'd0);
    serve(0, 32'h00A0_0113);
    chk("seq_pc_plus4", pc_plus4, 32'h8);
    chk("seq_opcode", {25'd0, opcode}, 32'h13);
    ack(1'b0, 32'd0);

    serve(5, $urandom);
    ack(1'b1, 32'h100);
    serve(1, $urandom);
    chk("redir_pc", pc, 32'h100);
    ack(1'b1, 32'hFFFF_FFFC);
    serve(0, $urandom);
    ack(1'b0, 32'd0);
    serve(0, $urandom);
    chk("wrap_pc", pc, 32'h0);
    ack(1'b0, 32'd0);

    for (int k = 0; k < 30; k++) begin
      serve($urandom_range(0, 4), $urandom);
      sel = ($urandom_range(0, 3) == 0);
      ack(sel, $urandom & 32'hFFFF_FFFC);
    end

    wait_req(ok);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rstw_instr", instr, 32'h0000_0013);
    chk("rstw_valid", {31'd0, instr_valid}, 32'd0);
    chk("rstw_pc", pc, RPC);
    mpc = RPC;
    req_q.push_back(RPC);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("stray_instr", instr, 32'h0000_0013);
    chk("stray_valid", {31'd0, instr_valid}, 32'd0);
    serve(0, $urandom);
    ack(1'b0, 32'd0);

    serve(0, $urandom);
    ack(1'b1, 32'h102);
`ifdef MISALIGN_TRAP_EN
    repeat (10) tick();
    chk("trap_err", {31'd0, misalign_err}, 32'd1);
    chk("trap_valid", {31'd0, instr_valid}, 32'd0);
    chk("trap_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    tick();
    chk("trap_clr", {31'd0, misalign_err}, 32'd0);
    mpc   = RPC;
    mhalt = 1'b0;
    merr  = 1'b0;
    req_q.push_back(RPC);
    rst = 1'b0;
    serve(0, $urandom);
    ack(1'b0, 32'd0);
`else
    serve(0, $urandom);
    chk("mask_pc", pc, 32'h100);
    chk("mask_err", {31'd0, misalign_err}, 32'd0);
    ack(1'b0, 32'd0);
`endif

    wait_req(ok);
    repeat (2) tick();
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("ins_q_empty", ins_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
